fix_frame_detector: RTL and testbench
=====================================

// Module: fix_frame_detector
// PURPOSE
//  Upstream stage of the message-location controller. Accepts the raw FIX byte stream and writes
//  framed bytes into the circular message buffer. Detects message start ("8=" at frame start) and
//  end ("10=ddd<SOH>" at field start), validates the checksum, and pulses start/end with addresses.
//  Bad frames are dropped by rewinding the write pointer.
// PARAMETERS
//  DATA_WIDTH   5    buffer address width; buffer depth = 2**DATA_WIDTH bytes
//  MAX_LEN      31   max bytes per message incl. trailer; longer frames abort (must be < 2**DATA_WIDTH)
// PORTS
//  clk              in   1           clock, all state on rising edge
//  rst              in   1           asynchronous, active-high reset
//  data_i           in   8           input byte
//  valid_i          in   1           data_i valid; byte accepted when valid_i && ready_o
//  ready_o          out  1           = !full_o
//  rd_ptr_i         in   DATA_WIDTH  consumer read pointer (oldest unreleased byte)
//  we_o             out  1           buffer write enable
//  waddr_o          out  DATA_WIDTH  buffer write address
//  wdata_o          out  8           buffer write data
//  start_message_o  out  1           1-cycle pulse: valid message start
//  start_addr_o     out  DATA_WIDTH  address of the '8'; held until next start pulse
//  end_message_o    out  1           1-cycle pulse: valid message end
//  end_addr_o       out  DATA_WIDTH  address of final SOH; held until next end pulse
//  full_o           out  1           (wptr+1) mod depth == rd_ptr_i
//  err_o            out  1           1-cycle pulse: frame dropped (bad header/checksum/overlength)
// BEHAVIOUR
//  Reset (async): all outputs 0. wptr, sum, snap_sum, len and ck_val = 0. State = IDLE.
//  Write path: an accepted byte in any state except IDLE is written that cycle. In IDLE, only
//  '8' is written. we_o=1, waddr_o=wptr, wdata_o=data_i. wptr then increments mod 2**DATA_WIDTH.
//  FSM (transitions only on accepted bytes):
//   IDLE: '8' -> H8, latch sa=wptr, sum=0x38, len=1. Any other byte is discarded, not written.
//   H8: '=' -> BODY, field_start=0. Next cycle: start_message_o=1, start_addr_o=sa.
//       Any other byte -> IDLE, wptr=sa; no err_o. The byte is not re-examined.
//   BODY: sum+=byte. On SOH: snap_sum=sum (incl. SOH), field_start=1.
//         If field_start && byte=='1' -> T1; otherwise field_start=0.
//   T1: '0' -> T10, else BODY. T10: '=' -> CK0 with ck_val=0, else BODY. All add to sum.
//   CK0/CK1/CK2: expect ASCII digit; ck_val=ck_val*10+(byte-0x30), 10-bit.
//       A non-digit aborts.
//   CKS: expect SOH. If ck_val==snap_sum (8-bit sum mod 256): next cycle end_message_o=1,
//        end_addr_o=this byte's address, -> IDLE. Otherwise abort.
//   Abort: err_o=1 next cycle, wptr=sa, -> IDLE; no end_message_o.
//  Length: len increments per written byte. If len would exceed MAX_LEN, that byte is not written
//   and the frame aborts.
//  Full: ready_o=0 while full; input stalls and no state change. full_o is combinational from
//   wptr and rd_ptr_i. Wrap: wptr rolls from 2**DATA_WIDTH-1 to 0; a frame may straddle it.
//  Pulse spacing: start and end never coincide. Next start_message_o comes at least 2 cycles
//   after end_message_o, as the downstream FSM needs.
//  rd_ptr_i change and write in same cycle: full_o for that cycle uses the current values.
//  Latency: 1 cycle from accepting '=' / final SOH to the start/end pulse.
// TESTING
//  1 wptr=0, "8=A\x0110=183\x01" -> start pulse addr 0 after byte 2; end pulse addr 10; wptr=11.
//  2 "8=A\x0110=184\x01" -> err_o pulse, no end pulse, wptr back to 0; next good frame starts at 0.
//  3 "xx8x8=..." -> "xx" and first '8' dropped; start_addr = address of second '8'.
//  4 wptr=29, rd_ptr_i=0, scenario-1 frame -> waddr wraps 31->0, end_addr=7,
//    ready_o low when wptr=31, resumes when rd_ptr_i advances.
//  5 body "8=A\x01210=...": "10=" not at field start -> no trailer match; ~40-byte frame -> abort at len 32.
//  6 assert rst mid-BODY (async, between edges) -> outputs 0 immediately; after release "8=" restarts at addr 0.

Source files
------------

// File: rtl/fix_frame_detector_if.sv
// Byte-stream and buffer-write bundle for the FIX frame detector.
// The source/consumer side takes the master view; the detector takes the slave view.
interface fix_frame_detector_if #(
    parameter int DATA_WIDTH = 5
);
    logic [7:0]            data_i;
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] rd_ptr_i;
    logic                  we_o;
    logic [DATA_WIDTH-1:0] waddr_o;
    logic [7:0]            wdata_o;
    logic                  start_message_o;
    logic [DATA_WIDTH-1:0] start_addr_o;
    logic                  end_message_o;
    logic [DATA_WIDTH-1:0] end_addr_o;
    logic                  full_o;
    logic                  err_o;

    modport master (
        output data_i, valid_i, rd_ptr_i,
        input  ready_o, we_o, waddr_o, wdata_o, start_message_o, start_addr_o,
               end_message_o, end_addr_o, full_o, err_o
    );

    modport slave (
        input  data_i, valid_i, rd_ptr_i,
        output ready_o, we_o, waddr_o, wdata_o, start_message_o, start_addr_o,
               end_message_o, end_addr_o, full_o, err_o
    );
endinterface

// File: rtl/fix_frame_detector.sv
// FIX frame detector: frames the raw byte stream into the circular message buffer,
// finds "8=" headers and "10=ddd<SOH>" trailers, validates the checksum and
// rewinds the write pointer over frames that turn out to be bad.
module fix_frame_detector #(
    parameter int DATA_WIDTH = 5,
    parameter int MAX_LEN    = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    fix_frame_detector_if.slave  bus
);
    localparam int                    LEN_W   = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]      LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]      LEN_ONE = LEN_W'(1);
    localparam logic [DATA_WIDTH-1:0] PTR_ONE = DATA_WIDTH'(1);

    localparam logic [7:0] CH_SOH = 8'h01;
    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_1   = 8'h31;
    localparam logic [7:0] CH_8   = 8'h38;
    localparam logic [7:0] CH_EQ  = 8'h3D;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_H8   = 4'd1;
    localparam logic [3:0] S_BODY = 4'd2;
    localparam logic [3:0] S_T1   = 4'd3;
    localparam logic [3:0] S_T10  = 4'd4;
    localparam logic [3:0] S_CK0  = 4'd5;
    localparam logic [3:0] S_CK1  = 4'd6;
    localparam logic [3:0] S_CK2  = 4'd7;
    localparam logic [3:0] S_CKS  = 4'd8;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    logic [3:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] wptr_q, wptr_d;
    logic [DATA_WIDTH-1:0] sa_q, sa_d;
    logic [7:0]            sum_q, sum_d;
    logic [7:0]            snap_sum_q, snap_sum_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [9:0]            ck_val_q, ck_val_d;
    logic                  field_start_q, field_start_d;
    logic                  start_q, start_d;
    logic [DATA_WIDTH-1:0] start_addr_q, start_addr_d;
    logic                  end_q, end_d;
    logic [DATA_WIDTH-1:0] end_addr_q, end_addr_d;
    logic                  err_q, err_d;

    logic       full;
    logic       ready;
    logic       accept;
    logic       we;
    logic       abort;
    logic [7:0] sum_next;
    logic [9:0] ck_next;

    // Flow control: full compares the live write pointer against the live read pointer;
    // both are forced low while reset is asserted so every output reads 0 during reset.
    always_comb begin
        full   = ~rst & ((wptr_q + PTR_ONE) == bus.rd_ptr_i);
        ready  = ~rst & ~full;
        accept = bus.valid_i & ready;
    end

    // Frame parser: decides what to write, tracks checksum/length, and schedules pulses.
    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        sa_d          = sa_q;
        sum_d         = sum_q;
        snap_sum_d    = snap_sum_q;
        len_d         = len_q;
        ck_val_d      = ck_val_q;
        field_start_d = field_start_q;
        start_addr_d  = start_addr_q;
        end_addr_d    = end_addr_q;
        start_d       = 1'b0;
        end_d         = 1'b0;
        err_d         = 1'b0;
        we            = 1'b0;
        abort         = 1'b0;
        sum_next      = sum_q + bus.data_i;
        // For an ASCII digit, byte - '0' is the digit value.
        ck_next       = ck_val_q * 10'd10 + {2'b00, bus.data_i - CH_0};

        if (accept) begin
            if (state_q == S_IDLE) begin
                if (bus.data_i == CH_8) begin
                    we      = 1'b1;
                    wptr_d  = wptr_q + PTR_ONE;
                    sa_d    = wptr_q;
                    sum_d   = CH_8;
                    len_d   = LEN_ONE;
                    state_d = S_H8;
                end
            end else if (len_q == LEN_MAX) begin
                // One more byte would overrun the frame limit: drop it and the frame.
                abort = 1'b1;
            end else begin
                we     = 1'b1;
                wptr_d = wptr_q + PTR_ONE;
                len_d  = len_q + LEN_ONE;
                sum_d  = sum_next;
                case (state_q)
                    S_H8: begin
                        if (bus.data_i == CH_EQ) begin
                            state_d       = S_BODY;
                            field_start_d = 1'b0;
                            start_d       = 1'b1;
                            start_addr_d  = sa_q;
                        end else begin
                            // Not a header after all: quietly forget the '8'.
                            state_d = S_IDLE;
                            wptr_d  = sa_q;
                        end
                    end
                    S_BODY: begin
                        if (bus.data_i == CH_SOH) begin
                            snap_sum_d    = sum_next;
                            field_start_d = 1'b1;
                        end else if (field_start_q && (bus.data_i == CH_1)) begin
                            state_d       = S_T1;
                            field_start_d = 1'b0;
                        end else begin
                            field_start_d = 1'b0;
                        end
                    end
                    S_T1, S_T10: begin
                        if ((state_q == S_T1) && (bus.data_i == CH_0)) begin
                            state_d = S_T10;
                        end else if ((state_q == S_T10) && (bus.data_i == CH_EQ)) begin
                            state_d  = S_CK0;
                            ck_val_d = 10'd0;
                        end else begin
                            // Partial "10=" falls back to the body; an SOH here still ends a field.
                            state_d       = S_BODY;
                            field_start_d = (bus.data_i == CH_SOH);
                            if (bus.data_i == CH_SOH) begin
                                snap_sum_d = sum_next;
                            end
                        end
                    end
                    S_CK0, S_CK1, S_CK2: begin
                        if (is_digit(bus.data_i)) begin
                            ck_val_d = ck_next;
                            state_d  = (state_q == S_CK0) ? S_CK1 :
                                       (state_q == S_CK1) ? S_CK2 : S_CKS;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                    S_CKS: begin
                        if ((bus.data_i == CH_SOH) && (ck_val_q == {2'b00, snap_sum_q})) begin
                            end_d      = 1'b1;
                            end_addr_d = wptr_q;
                            state_d    = S_IDLE;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end

            if (abort) begin
                err_d   = 1'b1;
                wptr_d  = sa_q;
                state_d = S_IDLE;
            end
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wptr_q        <= '0;
            sa_q          <= '0;
            sum_q         <= '0;
            snap_sum_q    <= '0;
            len_q         <= '0;
            ck_val_q      <= '0;
            field_start_q <= 1'b0;
            start_q       <= 1'b0;
            start_addr_q  <= '0;
            end_q         <= 1'b0;
            end_addr_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            sa_q          <= sa_d;
            sum_q         <= sum_d;
            snap_sum_q    <= snap_sum_d;
            len_q         <= len_d;
            ck_val_q      <= ck_val_d;
            field_start_q <= field_start_d;
            start_q       <= start_d;
            start_addr_q  <= start_addr_d;
            end_q         <= end_d;
            end_addr_q    <= end_addr_d;
            err_q         <= err_d;
        end
    end

    assign bus.ready_o         = ready;
    assign bus.full_o          = full;
    assign bus.we_o            = we;
    assign bus.waddr_o         = wptr_q;
    assign bus.wdata_o         = we ? bus.data_i : 8'h00;
    assign bus.start_message_o = start_q;
    assign bus.start_addr_o    = start_addr_q;
    assign bus.end_message_o   = end_q;
    assign bus.end_addr_o      = end_addr_q;
    assign bus.err_o           = err_q;
endmodule

// File: tb/tb_fix_frame_detector.sv
// Bench for fix_frame_detector: directed scenarios plus randomized frames, every cycle
// compared against a frame-level reference model (byte queue + pattern rules).
module tb_fix_frame_detector;
    localparam int DW    = 5;
    localparam int MAXL  = 31;
    localparam int DEPTH = 1 << DW;

    logic clk;
    logic rst;

    fix_frame_detector_if #(.DATA_WIDTH(DW)) bus ();

    fix_frame_detector #(.DATA_WIDTH(DW), .MAX_LEN(MAXL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    // Reference model: the bytes of the frame in progress, where it started,
    // and the index of the trailer's '=' once "<SOH>10=" has been seen.
    int         m_wptr;
    int         m_sa;
    int         m_tr;
    logic [7:0] m_q[$];
    logic       e_start, e_end, e_err;
    int         e_saddr, e_eaddr;

    int n_start, n_end, n_err, last_saddr, last_eaddr;
    bit rd_rand, rd_follow, gap_rand;
    logic [7:0] fr[$];
    logic [7:0] alpha [8] = '{8'h41, 8'h31, 8'h30, 8'h3D, 8'h01, 8'h39, 8'h38, 8'h5A};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_wptr = 0; m_sa = 0; m_tr = -1; m_q.delete();
        e_start = 0; e_end = 0; e_err = 0; e_saddr = 0; e_eaddr = 0;
    endtask

    task automatic model_abort();
        e_err = 1; m_wptr = m_sa; m_q.delete(); m_tr = -1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int n, k, val, s, wa;
        if (m_q.size() == 0) begin
            if (b == 8'h38) begin
                m_sa = m_wptr; m_q.push_back(b); m_wptr = (m_wptr + 1) % DEPTH;
            end
            return;
        end
        if (m_q.size() >= MAXL) begin
            model_abort();
            return;
        end
        wa = m_wptr;
        m_q.push_back(b);
        m_wptr = (m_wptr + 1) % DEPTH;
        n = m_q.size();
        if (n == 2) begin
            if (b == 8'h3D) begin e_start = 1; e_saddr = m_sa; end
            else begin m_wptr = m_sa; m_q.delete(); end
            return;
        end
        if (m_tr < 0) begin
            if (n >= 6 && m_q[n-4] == 8'h01 && m_q[n-3] == 8'h31 && m_q[n-2] == 8'h30 && b == 8'h3D)
                m_tr = n - 1;
            return;
        end
        k = n - 1 - m_tr;
        if (k <= 3) begin
            if (b < 8'h30 || b > 8'h39) model_abort();
            return;
        end
        val = (int'(m_q[m_tr+1]) - 48) * 100 + (int'(m_q[m_tr+2]) - 48) * 10 + (int'(m_q[m_tr+3]) - 48);
        s = 0;
        for (int i = 0; i <= m_tr - 3; i++) s += int'(m_q[i]);
        if (b == 8'h01 && val == (s % 256)) begin
            e_end = 1; e_eaddr = wa; m_q.delete(); m_tr = -1;
        end else begin
            model_abort();
        end
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, advance the model.
    task automatic cyc(input logic v, input logic [7:0] b, output bit acc);
        bit full, wr;
        if (rd_follow) bus.rd_ptr_i = DW'(m_wptr);
        else if (rd_rand && $urandom_range(0, 3) == 0) bus.rd_ptr_i = DW'($urandom_range(0, DEPTH - 1));
        bus.valid_i = v;
        bus.data_i  = b;
        @(negedge clk);
        full = (((m_wptr + 1) % DEPTH) == int'(bus.rd_ptr_i));
        acc  = v && !full;
        wr   = acc && ((m_q.size() == 0 && b == 8'h38) || (m_q.size() > 0 && m_q.size() < MAXL));
        chk("full_o",     32'(bus.full_o),          32'(full));
        chk("ready_o",    32'(bus.ready_o),         32'(!full));
        chk("we_o",       32'(bus.we_o),            32'(wr));
        chk("waddr_o",    32'(bus.waddr_o),         32'(m_wptr));
        chk("wdata_o",    32'(bus.wdata_o),         wr ? 32'(b) : 32'd0);
        chk("start_o",    32'(bus.start_message_o), 32'(e_start));
        chk("start_addr", 32'(bus.start_addr_o),    32'(e_saddr));
        chk("end_o",      32'(bus.end_message_o),   32'(e_end));
        chk("end_addr",   32'(bus.end_addr_o),      32'(e_eaddr));
        chk("err_o",      32'(bus.err_o),           32'(e_err));
        if (bus.start_message_o === 1'b1) begin n_start++; last_saddr = int'(bus.start_addr_o); end
        if (bus.end_message_o === 1'b1)   begin n_end++;   last_eaddr = int'(bus.end_addr_o);   end
        if (bus.err_o === 1'b1) n_err++;
        e_start = 0; e_end = 0; e_err = 0;
        if (acc) model_byte(b);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bit acc, dummy;
        int guard;
        if (gap_rand && $urandom_range(0, 4) == 0) cyc(1'b0, 8'($urandom), dummy);
        guard = 0; acc = 0;
        while (!acc && guard < 200) begin cyc(1'b1, b, acc); guard++; end
        chk("accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bit dummy;
        for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom), dummy);
    endtask

    // '|' stands for SOH in frame text.
    task automatic push_str(input string s);
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            c = s.getc(i);
            fr.push_back(c == 8'h7C ? 8'h01 : 8'(c));
        end
    endtask

    task automatic push_ck(input int v);
        fr.push_back(8'h30 + 8'(v / 100));
        fr.push_back(8'h30 + 8'((v / 10) % 10));
        fr.push_back(8'h30 + 8'(v % 10));
    endtask

    task automatic send_fr();
        foreach (fr[i]) send(fr[i]);
    endtask

    task automatic send_str(input string s);
        fr.delete(); push_str(s); send_fr();
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b1;
        bus.valid_i = 1'b0;
        #1;
        chk("rst_ready",      32'(bus.ready_o),         32'd0);
        chk("rst_full",       32'(bus.full_o),          32'd0);
        chk("rst_we",         32'(bus.we_o),            32'd0);
        chk("rst_waddr",      32'(bus.waddr_o),         32'd0);
        chk("rst_wdata",      32'(bus.wdata_o),         32'd0);
        chk("rst_start",      32'(bus.start_message_o), 32'd0);
        chk("rst_start_addr", 32'(bus.start_addr_o),    32'd0);
        chk("rst_end",        32'(bus.end_message_o),   32'd0);
        chk("rst_end_addr",   32'(bus.end_addr_o),      32'd0);
        chk("rst_err",        32'(bus.err_o),           32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, e0, r0, sum, kind, nf, fl;
        bit acc;
        n_chk = 0; n_pass = 0;
        n_start = 0; n_end = 0; n_err = 0; last_saddr = -1; last_eaddr = -1;
        rd_rand = 0; rd_follow = 1; gap_rand = 0;
        rst = 1'b1;
        bus.valid_i = 1'b0; bus.data_i = 8'h00; bus.rd_ptr_i = '0;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // Good frame at address 0.
        s0 = n_start; e0 = n_end;
        send_str("8=A|10=183|"); idle(2);
        chk("t1_start_cnt",  32'(n_start - s0), 32'd1);
        chk("t1_start_addr", 32'(last_saddr),   32'd0);
        chk("t1_end_cnt",    32'(n_end - e0),   32'd1);
        chk("t1_end_addr",   32'(last_eaddr),   32'd10);
        chk("t1_wptr",       32'(bus.waddr_o),  32'd11);

        // Bad checksum is dropped and the pointer rewinds.
        apply_reset();
        e0 = n_end; r0 = n_err;
        send_str("8=A|10=184|"); idle(2);
        chk("t2_err_cnt", 32'(n_err - r0),  32'd1);
        chk("t2_end_cnt", 32'(n_end - e0),  32'd0);
        chk("t2_wptr",    32'(bus.waddr_o), 32'd0);
        send_str("8=A|10=183|"); idle(2);
        chk("t2_next_start", 32'(last_saddr), 32'd0);
        chk("t2_next_end",   32'(last_eaddr), 32'd10);

        // Junk and a false '8' ahead of a real header.
        send_str("xx8x8=A|10=183|"); idle(2);
        chk("t3_start_addr", 32'(last_saddr), 32'd11);
        chk("t3_end_addr",   32'(last_eaddr), 32'd21);

        // "10=" away from a field start never closes the frame; it aborts on length.
        apply_reset();
        e0 = n_end; r0 = n_err;
        fr.delete(); push_str("8=A|210=");
        for (int i = 0; i < 40; i++) fr.push_back(8'h42);
        send_fr(); idle(2);
        chk("t5_err_cnt", 32'(n_err - r0),  32'd1);
        chk("t5_end_cnt", 32'(n_end - e0),  32'd0);
        chk("t5_wptr",    32'(bus.waddr_o), 32'd0);

        // Reset in the middle of a body, then restart at address 0.
        s0 = n_start;
        send_str("8=AB");
        apply_reset();
        send_str("8=A|10=183|"); idle(2);
        chk("t6_start_cnt",  32'(n_start - s0), 32'd2);
        chk("t6_start_addr", 32'(last_saddr),   32'd0);
        chk("t6_end_addr",   32'(last_eaddr),   32'd10);

        // Frame straddling the wrap point, stalled by a full buffer.
        apply_reset();
        rd_follow = 0; bus.rd_ptr_i = '0;
        send_str("8=A|10=183|");
        send_str("8=ABCDEFGH|10=154|");
        chk("t4_wptr29", 32'(bus.waddr_o), 32'd29);
        send_str("8=");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h41, acc);
            chk("t4_stall_ready", 32'(bus.ready_o), 32'd0);
        end
        bus.rd_ptr_i = DW'(20);
        send_str("A|10=183|"); idle(2);
        chk("t4_start_addr", 32'(last_saddr),  32'd29);
        chk("t4_end_addr",   32'(last_eaddr),  32'd7);
        chk("t4_wptr",       32'(bus.waddr_o), 32'd8);

        // Randomized traffic with a wandering read pointer and valid gaps.
        apply_reset();
        rd_rand = 1; gap_rand = 1;
        for (int f = 0; f < 200; f++) begin
            kind = $urandom_range(0, 7);
            fr.delete();
            if (kind <= 4) begin
                push_str("8=");
                nf = $urandom_range(0, 3);
                for (int j = 0; j < nf; j++) begin
                    fl = $urandom_range(1, 5);
                    for (int c = 0; c < fl; c++) fr.push_back(alpha[$urandom_range(0, 7)]);
                    fr.push_back(8'h01);
                end
                if (nf == 0) fr.push_back(8'h01);
                sum = 0;
                foreach (fr[i]) sum += int'(fr[i]);
                sum = sum % 256;
                push_str("10=");
                if (kind == 3) push_ck(sum + $urandom_range(1, 200));
                else push_ck(sum);
                if (kind == 4) fr[fr.size() - 2] = 8'h58;
                fr.push_back(8'h01);
            end else if (kind == 5) begin
                fl = $urandom_range(1, 10);
                for (int c = 0; c < fl; c++) fr.push_back(alpha[$urandom_range(0, 7)]);
            end else if (kind == 6) begin
                fr.push_back(8'h38);
                fr.push_back(alpha[$urandom_range(0, 7)]);
            end
            if (kind == 7) idle($urandom_range(1, 4));
            else send_fr();
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
